// File: rtl/stream_mux_pkg.sv
// Shared definitions for the N:1 valid/ready stream multiplexer.
package stream_mux_pkg;

    // Arbitration mode encodings for the mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Width of a channel index for a given channel count (at least one bit).
    function automatic int sel_width(input int channels);
        return (channels < 2) ? 1 : $clog2(channels);
    endfunction

endpackage : stream_mux_pkg

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// Combinational rotate-priority encoder: the channel just after ptr has the
// highest priority, wrapping modulo CHANNELS, so the last-served channel
// ends up with the lowest priority.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [SEL_W-1:0]    ptr_i,
    output logic [SEL_W-1:0]    grant_o,
    output logic                grant_valid_o
);

    // Walk the search order from the farthest to the nearest slot so the
    // nearest requester after ptr is the last (winning) assignment.
    always_comb begin
        int idx;
        grant_o       = '0;
        grant_valid_o = 1'b0;
        idx           = 0;
        for (int k = CHANNELS; k >= 1; k--) begin
            idx = (int'(ptr_i) + k) % CHANNELS;
            if (req_i[idx]) begin
                grant_o       = idx[SEL_W-1:0];
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/stream_mux_nto1.sv
// N:1 valid/ready stream multiplexer with one registered output stage.
// Fixed-select or round-robin arbitration; full throughput while the
// downstream is ready, one beat of buffering under back-pressure.
module stream_mux_nto1
    import stream_mux_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // Output stage and arbitration pointer state.
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_chan_q,  out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    logic             load_en;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_grant_valid;
    logic             fixed_valid;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             transfer;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] ch_data [CHANNELS];

    // Unpack the flat channel bus into per-channel words.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
        assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    // The stage can accept when empty or when its beat drains this cycle.
    assign load_en = !out_valid_q || out_ready;

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_rr_arbiter (
        .req_i         (in_valid),
        .ptr_i         (ptr_q),
        .grant_o       (rr_grant),
        .grant_valid_o (rr_grant_valid)
    );

    // Fixed-mode request lookup; an out-of-range sel matches no channel
    // and therefore never grants.
    always_comb begin
        fixed_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i)) begin
                fixed_valid = in_valid[i];
            end
        end
    end

    // Pick the grant source according to the current mode.
    always_comb begin
        if (mode == MODE_RR) begin
            grant       = rr_grant;
            grant_valid = rr_grant_valid;
        end else begin
            grant       = sel;
            grant_valid = fixed_valid;
        end
    end

    // One-hot ready, held low throughout reset.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
        assign in_ready[gi] = !rst && load_en && grant_valid && (grant == SEL_W'(gi));
    end

    assign transfer = |(in_valid & in_ready);

    // AND-OR data select driven by the one-hot ready vector.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_ready[i]) begin
                sel_data = ch_data[i];
            end
        end
    end

    // Next state of the output stage and pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (transfer) begin
            out_data_d  = sel_data;
            out_chan_d  = grant;
            out_valid_d = 1'b1;
            ptr_d       = grant;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Register update; reset parks ptr on the last channel so channel 0 leads.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SEL_W'(CHANNELS - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule : stream_mux_nto1

// File: doc/stream_mux_nto1.md
Name: stream_mux_nto1

Overview:
- Parametrised successor to the 1-bit 2:1 gate-level multiplexer.
- Selects one of CHANNELS valid/ready input streams, each WIDTH bits wide, and forwards it through a single registered output stage.
- Two arbitration modes: fixed select (external sel) and round-robin.
- Sits between the ALU operand sources and the ALU input register, with one beat of buffering and full throughput.

Parameters:
- WIDTH, 8, data width per channel in bits.
- CHANNELS, 4, number of input streams, minimum 2.
- SEL_W, clog2(CHANNELS), derived localparam, width of sel and out_chan; not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed select via sel, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; combinational.
- out_data  output  WIDTH  registered selected data.
- out_chan  output  SEL_W  registered index of the channel that produced out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset, when rst=1 at a clk edge: out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=CHANNELS-1, so channel 0 has first priority.
- While rst is held, in_ready=0 on every channel.
- load_en = !out_valid || out_ready. The output stage can take a new beat when it is empty or is being drained in the same cycle.
- Fixed mode (mode=0):
  - grant = sel.
  - grant_valid = in_valid[sel] && (sel < CHANNELS).
  - An out-of-range sel never grants.
- Round-robin mode (mode=1):
  - Search channels ptr+1, ptr+2, … ptr+CHANNELS, modulo CHANNELS.
  - The first channel found with in_valid=1 is granted.
  - grant_valid = |in_valid.
- in_ready[i] = load_en && grant_valid && (grant == i). At most one in_ready is high per cycle.
- Transfer on channel i occurs when in_valid[i] && in_ready[i]. At the clk edge:
  - out_data <= channel i data.
  - out_chan <= i.
  - out_valid <= 1.
  - ptr <= i. ptr updates in both modes, so a switch to round-robin continues fairly from the last served channel.
- No transfer and out_ready=1: out_valid <= 0; out_data and out_chan hold their values.
- No transfer and out_ready=0: all registers hold.
- Latency: one clk from input handshake to out_valid.
- Throughput: one beat per cycle while out_ready=1.
- Back-pressure: while out_valid=1 and out_ready=0, the output stage holds stable and all in_ready=0.
- in_valid must stay asserted until accepted (standard valid/ready rule). The block does not check this.
- Mode or sel changes take effect in the same cycle's arbitration. A beat already held in the output register is unaffected.
- Simultaneous drain and load: the held beat leaves and the new beat enters on the same edge; out_valid stays 1.
- Reset mid-operation: the held beat is discarded, no in_ready is asserted in the reset cycle, and arbitration restarts at channel 0.
- Round-robin wrap-around: after serving channel CHANNELS-1, the search starts at channel 0.

Decomposition:
- Package stream_mux_pkg holds:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
  - A function computing SEL_W from CHANNELS.
- Sub-module rr_arbiter (parameter CHANNELS) is natural: combinational rotate-priority encoder.
  - Inputs: request vector and ptr.
  - Outputs: grant index and grant_valid.
- The top level owns ptr, the output register and the ready logic.

Test Plan:
1. Reset: drive rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0000 throughout.
2. Fixed mode: WIDTH=8, CHANNELS=4, mode=0, sel=2, ch2 data 8'hA5, all valid, out_ready=1 -> in_ready=0100; next cycle out_data=A5, out_chan=2, out_valid=1; channels 0, 1 and 3 are never accepted.
3. Round-robin fairness: mode=1, all 4 channels valid for 8 cycles, out_ready=1 -> out_chan sequence 0,1,2,3,0,1,2,3 with no bubble cycles.
4. Back-pressure: out_valid=1 holding 8'h3C, out_ready=0 for 3 cycles -> out_data stays 3C and in_ready=0000; when out_ready=1, the next granted beat loads on the same edge and out_valid stays 1.
5. Sparse round-robin and wrap: only ch1 and ch3 valid, ptr=3 -> grant order 1,3,1,3; then only ch0 valid after serving ch3 -> ch0 is granted.
6. Reset mid-stream and edge cases:
   - Assert rst while out_valid=1 -> out_valid=0 next cycle; the first grant after reset goes to ch0.
   - CHANNELS=3 with sel=3 in fixed mode -> no grant, in_ready=000.
